otter_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage OTTER (IF/DE/EX/MEM/WB). Keeps a shadow copy of
//  rd/rs/class info for the EX, MEM and WB slots. From it, drives the PC and pipeline-register

---
 rtl/otter_hazard_ctrl_if.sv | 40 ++++
 rtl/otter_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_otter_hazard_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/otter_hazard_ctrl_if.sv
// Control bundle between the OTTER decode/execute stages and the hazard sequencer.
// The master side supplies decoded DE fields and stage status; the slave side returns enables and selects.
interface otter_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) ();
  logic              de_valid;
  logic [REG_AW-1:0] de_rs1;
  logic [REG_AW-1:0] de_rs2;
  logic              de_rs1_used;
  logic              de_rs2_used;
  logic [REG_AW-1:0] de_rd;
  logic              de_reg_write;
  logic              de_is_load;
  logic              ex_redirect;
  logic              mem_busy;
  logic              pc_write;
  logic              ifde_write;
  logic              ifde_flush;
  logic              deex_flush;
  logic              pipe_write;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output de_valid, de_rs1, de_rs2, de_rs1_used, de_rs2_used, de_rd,
           de_reg_write, de_is_load, ex_redirect, mem_busy,
    input  pc_write, ifde_write, ifde_flush, deex_flush, pipe_write,
           fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  de_valid, de_rs1, de_rs2, de_rs1_used, de_rs2_used, de_rd,
           de_reg_write, de_is_load, ex_redirect, mem_busy,
    output pc_write, ifde_write, ifde_flush, deex_flush, pipe_write,
           fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/otter_hazard_ctrl.sv
// Hazard sequencer for the 5-stage OTTER pipeline: shadows EX/MEM/WB register usage and
// drives stall, flush, freeze and forwarding controls. It never touches datapath values.
module otter_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  otter_hazard_ctrl_if.slave   hz
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              is_load;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_used;
    logic              rs2_used;
  } slot_t;

  localparam logic WB_STALL = (WB_BYPASS == 0);

  slot_t            ex_reg, mem_reg, wb_reg;
  slot_t            ex_next, mem_next, wb_next;
  slot_t            de_slot;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
  logic             ex_load_hit, wb_hit, load_use;
  logic             freeze, redirect, stall;

  // x0 is hard-wired, so it never creates a dependency.
  function automatic logic writes(input slot_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.reg_write && (s.rd == r) && (r != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_AW-1:0] r,
                                         input slot_t m, input slot_t w);
    if (used && writes(m, r) && !m.is_load) return 2'b01;
    else if (writes(w, r))                  return 2'b10;
    else                                    return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  always_comb begin
    de_slot           = '0;
    de_slot.valid     = hz.de_valid;
    de_slot.rd        = hz.de_rd;
    de_slot.reg_write = hz.de_reg_write;
    de_slot.is_load   = hz.de_is_load;
    de_slot.rs1       = hz.de_rs1;
    de_slot.rs2       = hz.de_rs2;
    de_slot.rs1_used  = hz.de_rs1_used;
    de_slot.rs2_used  = hz.de_rs2_used;
  end

  always_comb begin
    ex_load_hit = ex_reg.valid && ex_reg.is_load &&
                  ((hz.de_rs1_used && writes(ex_reg, hz.de_rs1)) ||
                   (hz.de_rs2_used && writes(ex_reg, hz.de_rs2)));
    wb_hit      = WB_STALL &&
                  ((hz.de_rs1_used && writes(wb_reg, hz.de_rs1)) ||
                   (hz.de_rs2_used && writes(wb_reg, hz.de_rs2)));
    load_use    = hz.de_valid && (ex_load_hit || wb_hit);
    // A redirect outranks load-use because the DE instruction is on the wrong path.
    freeze      = hz.mem_busy;
    redirect    = !hz.mem_busy && hz.ex_redirect;
    stall       = !hz.mem_busy && !hz.ex_redirect && load_use;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ex_reg        <= '0;
      mem_reg       <= '0;
      wb_reg        <= '0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      ex_reg        <= ex_next;
      mem_reg       <= mem_next;
      wb_reg        <= wb_next;
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    ex_next        = ex_reg;
    mem_next       = mem_reg;
    wb_next        = wb_reg;
    stall_cnt_next = stall_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    if (freeze) begin
      ex_next = ex_reg;
    end else if (redirect || stall) begin
      ex_next  = '0;
      mem_next = ex_reg;
      wb_next  = mem_reg;
      if (redirect) flush_cnt_next = sat_inc(flush_cnt_reg);
      else          stall_cnt_next = sat_inc(stall_cnt_reg);
    end else begin
      ex_next  = de_slot;
      mem_next = ex_reg;
      wb_next  = mem_reg;
    end
  end

  // Output logic; during reset everything reflects the cleared state.
  always_comb begin
    hz.pc_write   = 1'b1;
    hz.ifde_write = 1'b1;
    hz.ifde_flush = 1'b0;
    hz.deex_flush = 1'b0;
    hz.pipe_write = 1'b1;
    hz.fwd_a_sel  = 2'b00;
    hz.fwd_b_sel  = 2'b00;
    if (!RESET) begin
      hz.fwd_a_sel = fwd_sel(ex_reg.rs1_used, ex_reg.rs1, mem_reg, wb_reg);
      hz.fwd_b_sel = fwd_sel(ex_reg.rs2_used, ex_reg.rs2, mem_reg, wb_reg);
      if (freeze) begin
        hz.pc_write   = 1'b0;
        hz.ifde_write = 1'b0;
        hz.pipe_write = 1'b0;
      end else if (redirect) begin
        hz.ifde_flush = 1'b1;
        hz.deex_flush = 1'b1;
      end else if (stall) begin
        hz.pc_write   = 1'b0;
        hz.ifde_write = 1'b0;
        hz.deex_flush = 1'b1;
      end
    end
  end

  assign hz.stall_cnt = stall_cnt_reg;
  assign hz.flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Directed scoreboard bench for otter_hazard_ctrl: dut_a uses the write-before-read regfile
// with 16-bit counters, dut_b stalls on WB hazards and has 2-bit counters to reach saturation.
module tb_otter_hazard_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic       dv = 1'b0, u1 = 1'b0, u2 = 1'b0, rw = 1'b0, ld = 1'b0;
  logic       redir = 1'b0, busy = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;

  // DE fields staged by set_de and applied by the next cyc call
  logic       p_dv = 1'b0, p_u1 = 1'b0, p_u2 = 1'b0, p_rw = 1'b0, p_ld = 1'b0;
  logic [4:0] p_rs1 = '0, p_rs2 = '0, p_rd = '0;

  otter_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) ia ();
  otter_hazard_ctrl_if #(.REG_AW(5), .CNT_W(2))  ib ();

  assign ia.de_valid = dv;     assign ib.de_valid = dv;
  assign ia.de_rs1 = rs1;      assign ib.de_rs1 = rs1;
  assign ia.de_rs2 = rs2;      assign ib.de_rs2 = rs2;
  assign ia.de_rs1_used = u1;  assign ib.de_rs1_used = u1;
  assign ia.de_rs2_used = u2;  assign ib.de_rs2_used = u2;
  assign ia.de_rd = rd;        assign ib.de_rd = rd;
  assign ia.de_reg_write = rw; assign ib.de_reg_write = rw;
  assign ia.de_is_load = ld;   assign ib.de_is_load = ld;
  assign ia.ex_redirect = redir; assign ib.ex_redirect = redir;
  assign ia.mem_busy = busy;   assign ib.mem_busy = busy;

  otter_hazard_ctrl #(.REG_AW(5), .WB_BYPASS(1), .CNT_W(16)) dut_a (
    .CLK(CLK), .RESET(rst_a), .hz(ia.slave));
  otter_hazard_ctrl #(.REG_AW(5), .WB_BYPASS(0), .CNT_W(2)) dut_b (
    .CLK(CLK), .RESET(rst_b), .hz(ib.slave));

  typedef struct {
    int         dut;
    string      name;
    logic [4:0] en;   // {pc_write, ifde_write, ifde_flush, deex_flush, pipe_write}
    logic [1:0] fa;
    logic [1:0] fb;
    int         sc;
    int         fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  localparam logic [4:0] NORM = 5'b11001;
  localparam logic [4:0] FRZ  = 5'b00000;
  localparam logic [4:0] RED  = 5'b11111;
  localparam logic [4:0] STL  = 5'b00011;

  task automatic set_de(input bit v, input int r1, input int r2, input bit a1, input bit a2,
                        input int d, input bit w, input bit l);
    p_dv = v; p_rs1 = 5'(r1); p_rs2 = 5'(r2); p_u1 = a1; p_u2 = a2;
    p_rd = 5'(d); p_rw = w; p_ld = l;
  endtask

  task automatic cyc(input string name, input int dut, input bit rst, input bit rdr,
                     input bit bz, input logic [4:0] en, input logic [1:0] fa,
                     input logic [1:0] fb, input int sc, input int fc);
    exp_t e;
    @(posedge CLK);
    #1;
    rst_a = (dut == 0) ? rst : 1'b1;
    rst_b = (dut == 1) ? rst : 1'b1;
    dv = p_dv; rs1 = p_rs1; rs2 = p_rs2; u1 = p_u1; u2 = p_u2;
    rd = p_rd; rw = p_rw; ld = p_ld;
    redir = rdr; busy = bz;
    e.dut = dut; e.name = name; e.en = en; e.fa = fa; e.fb = fb; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle whenever an expectation is queued.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [4:0] a_en;
      logic [1:0] a_fa, a_fb;
      int a_sc, a_fc;
      e = exp_q.pop_front();
      if (e.dut == 0) begin
        a_en = {ia.pc_write, ia.ifde_write, ia.ifde_flush, ia.deex_flush, ia.pipe_write};
        a_fa = ia.fwd_a_sel; a_fb = ia.fwd_b_sel;
        a_sc = int'(ia.stall_cnt); a_fc = int'(ia.flush_cnt);
      end else begin
        a_en = {ib.pc_write, ib.ifde_write, ib.ifde_flush, ib.deex_flush, ib.pipe_write};
        a_fa = ib.fwd_a_sel; a_fb = ib.fwd_b_sel;
        a_sc = int'(ib.stall_cnt); a_fc = int'(ib.flush_cnt);
      end
      checks++;
      if (a_en === e.en && a_fa === e.fa && a_fb === e.fb && a_sc == e.sc && a_fc == e.fc) begin
        passes++;
        $display("[%0t] %s dut%0d en=%b fa=%b fb=%b stall=%0d flush=%0d ok",
                 $time, e.name, e.dut, a_en, a_fa, a_fb, a_sc, a_fc);
      end else begin
        $display("[%0t] FAIL %s dut%0d got en=%b fa=%b fb=%b stall=%0d flush=%0d need en=%b fa=%b fb=%b stall=%0d flush=%0d",
                 $time, e.name, e.dut, a_en, a_fa, a_fb, a_sc, a_fc,
                 e.en, e.fa, e.fb, e.sc, e.fc);
      end
    end
  end

  initial begin
    // ---- dut_a: WB_BYPASS=1 ----
    set_de(0,0,0,0,0,0,0,0); cyc("a_reset",      0,1,0,0, NORM,2'b00,2'b00, 0,0);
    set_de(1,1,2,1,1,5,1,0); cyc("t1_add_x5",    0,0,0,0, NORM,2'b00,2'b00, 0,0);
    set_de(1,5,1,1,1,6,1,0); cyc("t1_sub_de",    0,0,0,0, NORM,2'b00,2'b00, 0,0);
    set_de(1,2,5,1,1,9,1,0); cyc("t1_fwd_mem",   0,0,0,0, NORM,2'b01,2'b00, 0,0);
    set_de(0,0,0,0,0,0,0,0); cyc("t1_fwd_wb",    0,0,0,0, NORM,2'b00,2'b10, 0,0);
    cyc("drain1",                                0,0,0,0, NORM,2'b00,2'b00, 0,0);
    cyc("drain2",                                0,0,0,0, NORM,2'b00,2'b00, 0,0);
    set_de(1,2,0,1,0,7,1,1); cyc("t2_lw_x7",     0,0,0,0, NORM,2'b00,2'b00, 0,0);
    set_de(1,7,7,1,1,8,1,0); cyc("t2_stall",     0,0,0,0, STL, 2'b00,2'b00, 0,0);
    cyc("t2_release",                            0,0,0,0, NORM,2'b00,2'b00, 1,0);
    set_de(0,0,0,0,0,0,0,0); cyc("t2_fwd_wb",    0,0,0,0, NORM,2'b10,2'b10, 1,0);
    set_de(1,2,0,1,0,7,1,1); cyc("t3_lw_x7",     0,0,0,0, NORM,2'b00,2'b00, 1,0);
    set_de(1,7,7,1,1,8,1,0); cyc("t3_redirect",  0,0,1,0, RED, 2'b00,2'b00, 1,0);
    set_de(0,0,0,0,0,0,0,0); cyc("t3_after",     0,0,0,0, NORM,2'b00,2'b00, 1,1);
    set_de(1,2,0,1,0,7,1,1); cyc("t4_lw_x7",     0,0,0,0, NORM,2'b00,2'b00, 1,1);
    set_de(1,7,7,1,1,8,1,0); cyc("t4_busy1",     0,0,0,1, FRZ, 2'b00,2'b00, 1,1);
    cyc("t4_busy2",                              0,0,0,1, FRZ, 2'b00,2'b00, 1,1);
    cyc("t4_busy3",                              0,0,0,1, FRZ, 2'b00,2'b00, 1,1);
    cyc("t4_stall",                              0,0,0,0, STL, 2'b00,2'b00, 1,1);
    cyc("t4_release",                            0,0,0,0, NORM,2'b00,2'b00, 2,1);
    set_de(0,0,0,0,0,0,0,0); cyc("fwd_in_freeze",0,0,0,1, FRZ, 2'b10,2'b10, 2,1);
    cyc("fwd_after_frz",                         0,0,0,0, NORM,2'b10,2'b10, 2,1);
    set_de(1,2,0,1,0,0,1,1); cyc("t5_lw_x0",     0,0,0,0, NORM,2'b00,2'b00, 2,1);
    set_de(1,0,0,1,1,4,1,0); cyc("t5_x0_nostall",0,0,0,0, NORM,2'b00,2'b00, 2,1);
    set_de(0,0,0,0,0,0,0,0); cyc("t5_x0_nofwd",  0,0,0,0, NORM,2'b00,2'b00, 2,1);
    cyc("redir_in_busy",                         0,0,1,1, FRZ, 2'b00,2'b00, 2,1);
    cyc("redir_pending",                         0,0,1,0, RED, 2'b00,2'b00, 2,1);
    cyc("redir_counted",                         0,0,0,0, NORM,2'b00,2'b00, 2,2);
    set_de(1,2,0,1,0,7,1,1); cyc("t6_lw_x7",     0,0,0,0, NORM,2'b00,2'b00, 2,2);
    set_de(1,7,7,1,1,8,1,0); cyc("t6_rst_stall", 0,1,0,0, NORM,2'b00,2'b00, 2,2);
    cyc("t6_after_rst",                          0,0,0,0, NORM,2'b00,2'b00, 0,0);

    // ---- dut_b: WB_BYPASS=0, 2-bit counters ----
    set_de(0,0,0,0,0,0,0,0); cyc("b_reset",      1,1,0,0, NORM,2'b00,2'b00, 0,0);
    set_de(1,1,0,1,0,3,1,0); cyc("b_addi_x3",    1,0,0,0, NORM,2'b00,2'b00, 0,0);
    set_de(0,0,0,0,0,0,0,0); cyc("b_nop1",       1,0,0,0, NORM,2'b00,2'b00, 0,0);
    cyc("b_nop2",                                1,0,0,0, NORM,2'b00,2'b00, 0,0);
    set_de(1,3,0,1,1,4,1,0); cyc("t5_wb_stall",  1,0,0,0, STL, 2'b00,2'b00, 0,0);
    cyc("t5_wb_release",                         1,0,0,0, NORM,2'b00,2'b00, 1,0);
    set_de(0,0,0,0,0,0,0,0); cyc("t5_wb_nofwd",  1,0,0,0, NORM,2'b00,2'b00, 1,0);
    for (int k = 0; k < 4; k++) begin
      int s;
      s = (k + 1 > 3) ? 3 : k + 1;
      set_de(1,2,0,1,0,7,1,1); cyc("sat_lw",     1,0,0,0, NORM,2'b00,2'b00, s,0);
      set_de(1,7,7,1,1,8,1,0); cyc("sat_stall",  1,0,0,0, STL, 2'b00,2'b00, s,0);
      set_de(0,0,0,0,0,0,0,0); cyc("sat_after",  1,0,0,0, NORM,2'b00,2'b00, (s + 1 > 3) ? 3 : s + 1,0);
    end
    set_de(1,2,0,1,0,7,1,1); cyc("b_lw_x7",      1,0,0,0, NORM,2'b00,2'b00, 3,0);
    set_de(1,7,7,1,1,8,1,0); cyc("b_rst_stall",  1,1,0,0, NORM,2'b00,2'b00, 3,0);
    cyc("b_after_rst",                           1,0,0,0, NORM,2'b00,2'b00, 0,0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL monitor_drain: %0d expectations left, need 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
